frame_ctrl: RTL

- Serial header parser and controller placed directly upstream of the 8-bit payload buffer/counter stage.
- Watches the serial input line for a frame, captures the destination address and the 8-bit length field, then loads the downstream counter.
- Holds that stage's counter-enable and tri-state-enable high for the payload bits, and releases them on the downstream carry-out.
- Raises a one-cycle done flag when the frame ends.

---
 rtl/frame_ctrl_pkg.sv | 34 +++
 rtl/frame_ctrl_if.sv | 33 +++
 rtl/frame_ctrl_sipo_shreg.sv | 44 ++++
 rtl/frame_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/frame_ctrl_pkg.sv
// frame_ctrl_pkg: shared types and constants for the serial frame header controller.
// Optional feature macro: FRAME_CTRL_PARITY_EN (adds an even-parity bit after the length field).
package frame_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    LEN    = 3'd2,
    PARITY = 3'd3,
    DATA   = 3'd4
  } state_t;

  localparam int ADDR_W_DEF = 2;
  localparam int LEN_W_DEF  = 8;

  localparam int START_W = 1;
`ifdef FRAME_CTRL_PARITY_EN
  localparam int PARITY_W = 1;
`else
  localparam int PARITY_W = 0;
`endif

  // Bit counter only has to reach the longer of the two header fields.
  function automatic int cnt_w(input int addr_w, input int len_w);
    int m;
    m = (addr_w > len_w) ? addr_w : len_w;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int hdr_bits(input int addr_w, input int len_w);
    return START_W + addr_w + len_w + PARITY_W;
  endfunction

endpackage

// File: rtl/frame_ctrl_if.sv
// frame_ctrl_if: serial line in, downstream counter control out.
// Optional feature macro: FRAME_CTRL_PARITY_EN (adds the err pulse).
interface frame_ctrl_if
  import frame_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();

  logic              SI;
  logic              co;
  logic              ld;
  logic [LEN_W-1:0]  PI;
  logic              en_cnt;
  logic              en_tri;
  logic [ADDR_W-1:0] port_sel;
  logic              busy;
  logic              done;
`ifdef FRAME_CTRL_PARITY_EN
  logic              err;

  modport master (output SI, co,
                  input  ld, PI, en_cnt, en_tri, port_sel, busy, done, err);
  modport slave  (input  SI, co,
                  output ld, PI, en_cnt, en_tri, port_sel, busy, done, err);
`else
  modport master (output SI, co,
                  input  ld, PI, en_cnt, en_tri, port_sel, busy, done);
  modport slave  (input  SI, co,
                  output ld, PI, en_cnt, en_tri, port_sel, busy, done);
`endif

endinterface

// File: rtl/frame_ctrl_sipo_shreg.sv
// sipo_shreg: serial-in parallel-out shift register, MSB first, with sync clear.
// o_q_next exposes the value being written this cycle so a caller can use the
// completed word in the same cycle its last bit arrives.
module sipo_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_shift_en,
  input  logic         i_clr,
  input  logic         i_sd,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_q_next
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_shifted;

  if (W == 1) begin : g_one
    assign w_shifted = i_sd;
  end else begin : g_many
    assign w_shifted = {r_q[W-2:0], i_sd};
  end

  // Clear wins over shift; otherwise hold.
  always_comb begin
    o_q_next = r_q;
    if (i_clr)
      o_q_next = '0;
    else if (i_shift_en)
      o_q_next = w_shifted;
  end

  // Register the next value.
  always_ff @(posedge clk) begin
    if (rst)
      r_q <= '0;
    else
      r_q <= o_q_next;
  end

  assign o_q = r_q;

endmodule

// File: rtl/frame_ctrl.sv
// frame_ctrl: parses start/address/length header from SI, loads the downstream
// payload counter and enables it until its carry-out ends the frame.
// Optional feature macro: FRAME_CTRL_PARITY_EN (even parity over addr+len,
// one extra PARITY cycle, err pulse on mismatch).
//
// state  | meaning
// IDLE   | waiting for start bit (SI=0)
// ADDR   | shifting in the destination address
// LEN    | shifting in the length field; ld on its last bit when no parity
// PARITY | checking parity bit; ld if good, err and back to IDLE if bad
// DATA   | payload: en_cnt/en_tri high until downstream co
module frame_ctrl
  import frame_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input logic        clk,
  input logic        rst,
  frame_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_w(ADDR_W, LEN_W);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_port_sel;
  logic              r_done;

  logic              w_start;
  logic              w_addr_shift;
  logic              w_len_shift;
  logic              w_addr_last;
  logic              w_len_last;
  logic              w_ld;
  logic [LEN_W-1:0]  w_pi;
  logic              w_en;
  logic              w_done_set;

  logic [ADDR_W-1:0] w_addr_q;
  logic [ADDR_W-1:0] w_addr_next;
  logic [LEN_W-1:0]  w_len_q;
  logic [LEN_W-1:0]  w_len_next;

`ifdef FRAME_CTRL_PARITY_EN
  logic              r_err;
  logic              w_err_set;
  logic              w_par_ok;

  // Even parity: address, length and the parity bit together hold an even number of ones.
  assign w_par_ok = ~^{w_addr_q, w_len_q, bus.SI};
`endif

  assign w_addr_last = (r_cnt == CNT_W'(ADDR_W - 1));
  assign w_len_last  = (r_cnt == CNT_W'(LEN_W - 1));

  sipo_shreg #(.W(ADDR_W)) u_addr_sr (
    .clk        (clk),
    .rst        (rst),
    .i_shift_en (w_addr_shift),
    .i_clr      (w_start),
    .i_sd       (bus.SI),
    .o_q        (w_addr_q),
    .o_q_next   (w_addr_next)
  );

  sipo_shreg #(.W(LEN_W)) u_len_sr (
    .clk        (clk),
    .rst        (rst),
    .i_shift_en (w_len_shift),
    .i_clr      (w_start),
    .i_sd       (bus.SI),
    .o_q        (w_len_q),
    .o_q_next   (w_len_next)
  );

  // Next-state and Moore/Mealy outputs.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_addr_shift = 1'b0;
    w_len_shift  = 1'b0;
    w_ld         = 1'b0;
    w_pi         = w_len_q;
    w_en         = 1'b0;
    w_done_set   = 1'b0;
`ifdef FRAME_CTRL_PARITY_EN
    w_err_set    = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (!bus.SI) begin
          w_start      = 1'b1;
          w_state_next = ADDR;
        end
      end
      ADDR: begin
        w_addr_shift = 1'b1;
        if (w_addr_last)
          w_state_next = LEN;
      end
      LEN: begin
        w_len_shift = 1'b1;
        if (w_len_last) begin
`ifdef FRAME_CTRL_PARITY_EN
          w_state_next = PARITY;
`else
          // Last length bit is still on SI, so present it through the bypass.
          w_ld         = 1'b1;
          w_pi         = w_len_next;
          w_state_next = DATA;
`endif
        end
      end
      PARITY: begin
`ifdef FRAME_CTRL_PARITY_EN
        if (w_par_ok) begin
          w_ld         = 1'b1;
          w_pi         = w_len_q;
          w_state_next = DATA;
        end else begin
          w_err_set    = 1'b1;
          w_state_next = IDLE;
        end
`else
        w_state_next = IDLE;
`endif
      end
      DATA: begin
        w_en = 1'b1;
        if (bus.co) begin
          w_done_set   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  // Bit counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_state_next != r_state)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  // Capture the completed address as ADDR hands over to LEN.
  always_ff @(posedge clk) begin
    if (rst)
      r_port_sel <= '0;
    else if (r_state == ADDR && w_addr_last)
      r_port_sel <= w_addr_next;
  end

  // One-cycle done pulse after the co cycle.
  always_ff @(posedge clk) begin
    if (rst)
      r_done <= 1'b0;
    else
      r_done <= w_done_set;
  end

`ifdef FRAME_CTRL_PARITY_EN
  // One-cycle err pulse after a bad parity cycle.
  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else
      r_err <= w_err_set;
  end

  assign bus.err = r_err;
`endif

  assign bus.ld       = w_ld;
  assign bus.PI       = w_pi;
  assign bus.en_cnt   = w_en;
  assign bus.en_tri   = w_en;
  assign bus.port_sel = r_port_sel;
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;

endmodule
